// File: rtl/edge_detect_pkg.sv
// rtl/edge_detect_pkg.sv - shared mode and state encodings for the multi-channel edge detector
package edge_detect_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // The state value is the last sampled level.
    typedef enum logic [0:0] {
        ST_ZERO = 1'b0,
        ST_ONE  = 1'b1
    } state_e;

endpackage

// File: rtl/edge_detect_multi_if.sv
// rtl/edge_detect_multi_if.sv - level/mode/clear inputs and event outputs of the edge detector
interface edge_detect_multi_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
);
    logic [NCH-1:0]       level;
    logic [2*NCH-1:0]     mode;
    logic [NCH-1:0]       clr;
    logic [NCH-1:0]       tick;
    logic                 any_tick;
    logic [NCH-1:0]       evt_flag;
    logic [NCH*CNT_W-1:0] evt_cnt;

    modport master (
        output level, mode, clr,
        input  tick, any_tick, evt_flag, evt_cnt
    );

    modport slave (
        input  level, mode, clr,
        output tick, any_tick, evt_flag, evt_cnt
    );
endinterface

// File: rtl/edge_detect_chan.sv
// rtl/edge_detect_chan.sv - one channel: optional synchronizer (EDGE_DETECT_SYNC_EN), FSM, tick, flag, counter
module edge_detect_chan
    import edge_detect_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             level,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic             tick,
    output logic             evt_flag,
    output logic [CNT_W-1:0] evt_cnt
);
    logic s;

`ifdef EDGE_DETECT_SYNC_EN
    logic sync1_q, sync1_d, sync2_q, sync2_d;

    always_comb begin
        sync1_d = level;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign s = sync2_q;
`else
    assign s = level;
`endif

    state_e state_q, state_d;
    logic   rise, fall;

    // State follows the level in every mode so enabling a channel sees no stale edge.
    always_comb begin
        state_d = state_q;
        rise    = 1'b0;
        fall    = 1'b0;
        case (state_q)
            ST_ZERO: if (s) begin
                state_d = ST_ONE;
                rise    = 1'b1;
            end
            ST_ONE: if (!s) begin
                state_d = ST_ZERO;
                fall    = 1'b1;
            end
            default: state_d = ST_ZERO;
        endcase
    end

    always_comb begin
        tick = 1'b0;
        if (!reset) begin
            case (mode)
                MODE_RISE: tick = rise;
                MODE_FALL: tick = fall;
                MODE_BOTH: tick = rise | fall;
                default:   tick = 1'b0;
            endcase
        end
    end

    logic             flag_q, flag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A tick coinciding with a clear wins: flag stays set and the count restarts at one.
    always_comb begin
        flag_d = flag_q;
        cnt_d  = cnt_q;
        if (clr) begin
            flag_d = 1'b0;
            cnt_d  = '0;
        end
        if (tick) begin
            flag_d = 1'b1;
            if (clr) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ZERO;
            flag_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
        end
    end

    assign evt_flag = flag_q;
    assign evt_cnt  = cnt_q;

endmodule

// File: rtl/edge_detect_multi.sv
// rtl/edge_detect_multi.sv - NCH-channel edge detector top; EDGE_DETECT_SYNC_EN adds input synchronizers
module edge_detect_multi
    import edge_detect_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    edge_detect_multi_if.slave bus
);
    logic [NCH-1:0]       tick_w;
    logic [NCH-1:0]       flag_w;
    logic [NCH*CNT_W-1:0] cnt_w;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        edge_detect_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .level    (bus.level[i]),
            .mode     (bus.mode[2*i +: 2]),
            .clr      (bus.clr[i]),
            .tick     (tick_w[i]),
            .evt_flag (flag_w[i]),
            .evt_cnt  (cnt_w[CNT_W*i +: CNT_W])
        );
    end

    assign bus.tick     = tick_w;
    assign bus.any_tick = |tick_w;
    assign bus.evt_flag = flag_w;
    assign bus.evt_cnt  = cnt_w;

endmodule

// File: tb/tb_edge_detect_multi.sv
// tb/tb_edge_detect_multi.sv - directed self-checking bench for edge_detect_multi (NCH=4, CNT_W=2)
module tb_edge_detect_multi;

`ifdef EDGE_DETECT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    edge_detect_multi_if #(.NCH(4), .CNT_W(2)) bus_if ();

    edge_detect_multi #(
        .NCH   (4),
        .CNT_W (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // New level enters after a clock edge; the tick it causes is sampled mid-cycle LAT cycles later.
    task automatic apply_level(input logic [3:0] v);
        next_cyc();
        bus_if.level = v;
        repeat (LAT) next_cyc();
        @(negedge clk);
    endtask

    initial begin
        reset        = 1'b1;
        bus_if.level = 4'b0000;
        bus_if.mode  = 8'b01_01_01_01;
        bus_if.clr   = 4'b0000;

        next_cyc();
        bus_if.level = 4'b0001;
        @(negedge clk);
        check("reset_tick", 32'(bus_if.tick), 32'h0);
        check("reset_any", 32'(bus_if.any_tick), 32'h0);
        check("reset_flag", 32'(bus_if.evt_flag), 32'h0);
        check("reset_cnt", 32'(bus_if.evt_cnt), 32'h0);

        next_cyc();
        reset = 1'b0;
        repeat (LAT) next_cyc();
        @(negedge clk);
        check("first_tick", 32'(bus_if.tick), 32'h1);
        check("first_any", 32'(bus_if.any_tick), 32'h1);
        next_cyc();
        @(negedge clk);
        check("first_flag", 32'(bus_if.evt_flag), 32'h1);
        check("first_cnt", 32'(bus_if.evt_cnt), 32'h01);

        // ch0 RISE, ch1 FALL, ch2 BOTH, ch3 OFF
        next_cyc();
        bus_if.mode = 8'b00_11_10_01;
        @(negedge clk);
        check("mode_chg_tick", 32'(bus_if.tick), 32'h0);

        apply_level(4'b0111);
        check("rise_fall_both", 32'(bus_if.tick), 32'h4);
        apply_level(4'b0001);
        check("fall_fall_both", 32'(bus_if.tick), 32'h6);
        next_cyc();
        @(negedge clk);
        check("fb_flag", 32'(bus_if.evt_flag), 32'h7);
        check("fb_cnt", 32'(bus_if.evt_cnt), 32'h25);

        apply_level(4'b1001);
        check("off_rise", 32'(bus_if.tick), 32'h0);
        apply_level(4'b0001);
        check("off_fall", 32'(bus_if.tick), 32'h0);
        apply_level(4'b1001);
        check("off_rise2", 32'(bus_if.tick), 32'h0);
        next_cyc();
        bus_if.mode = 8'b01_11_10_01;
        @(negedge clk);
        check("enable_no_stale", 32'(bus_if.tick), 32'h0);
        apply_level(4'b0001);
        check("rise_mode_fall", 32'(bus_if.tick), 32'h0);
        apply_level(4'b1001);
        check("enabled_rise", 32'(bus_if.tick), 32'h8);
        next_cyc();
        @(negedge clk);
        check("ch3_flag", 32'(bus_if.evt_flag), 32'hF);
        check("ch3_cnt", 32'(bus_if.evt_cnt), 32'h65);

        next_cyc();
        bus_if.clr = 4'b0001;
        next_cyc();
        bus_if.clr = 4'b0000;
        @(negedge clk);
        check("clr0_flag", 32'(bus_if.evt_flag), 32'hE);
        check("clr0_cnt", 32'(bus_if.evt_cnt), 32'h64);

        for (int k = 0; k < 5; k++) begin
            apply_level(4'b1000);
            apply_level(4'b1001);
            check($sformatf("sat_tick%0d", k), 32'(bus_if.tick), 32'h1);
            next_cyc();
            @(negedge clk);
            check($sformatf("sat_cnt%0d", k), 32'(bus_if.evt_cnt[1:0]), (k < 2) ? 32'(k + 1) : 32'd3);
        end

        apply_level(4'b1000);
        apply_level(4'b1001);
        bus_if.clr = 4'b0001;
        next_cyc();
        bus_if.clr = 4'b0000;
        @(negedge clk);
        check("clr_tick_cnt", 32'(bus_if.evt_cnt[1:0]), 32'd1);
        check("clr_tick_flag", 32'(bus_if.evt_flag[0]), 32'd1);

        next_cyc();
        bus_if.clr = 4'b0001;
        next_cyc();
        bus_if.clr = 4'b0000;
        @(negedge clk);
        check("clr_alone_cnt", 32'(bus_if.evt_cnt), 32'h64);
        check("clr_alone_flag", 32'(bus_if.evt_flag), 32'hE);

        apply_level(4'b1000);
        next_cyc();
        bus_if.level = 4'b1001;
        reset        = 1'b1;
        @(negedge clk);
        check("midreset_tick", 32'(bus_if.tick), 32'h0);
        check("midreset_any", 32'(bus_if.any_tick), 32'h0);
        next_cyc();
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_flag", 32'(bus_if.evt_flag), 32'h0);
        check("post_reset_cnt", 32'(bus_if.evt_cnt), 32'h0);
        if (LAT != 0) begin
            repeat (LAT) next_cyc();
            @(negedge clk);
        end
        check("post_reset_tick", 32'(bus_if.tick), 32'h9);
        next_cyc();
        @(negedge clk);
        check("post_reset_flag2", 32'(bus_if.evt_flag), 32'h9);
        check("post_reset_cnt2", 32'(bus_if.evt_cnt), 32'h41);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
